// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM state encoding
// and default geometry of the 64 x 64-bit instruction memory.
package fetch_pkg;

    localparam int unsigned DEF_ADDR_W   = 6;
    localparam int unsigned DEF_DATA_W   = 64;
    localparam int unsigned DEF_RESET_PC = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: redirect load, fetch increment with natural wrap, and a
// registered one-cycle pulse when an increment carries the PC from max to 0.
module fetch_pc_reg #(
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_addr,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_wrap_pulse
);

    logic [ADDR_W-1:0] r_pc;
    logic              r_wrap;

    // A load never pulses, even when it targets address 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc   <= ADDR_W'(RESET_PC);
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (i_load) begin
                r_pc <= i_load_addr;
            end else if (i_inc) begin
                r_pc   <= r_pc + ADDR_W'(1);
                r_wrap <= (r_pc == '1);
            end
        end
    end

    assign o_pc         = r_pc;
    assign o_wrap_pulse = r_wrap;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: IDLE/RUN/DRAIN FSM, one-entry registered output
// stage with valid/ready, branch flush. INSTR_FETCH_COUNT_EN enables fetch_count.
module instr_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned RESET_PC = DEF_RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              halt_req,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic              busy,
    output logic              wrap_pulse,
    output logic [31:0]       fetch_count
);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic              w_advance;
    logic              w_accept;
    logic              w_fetch;
    logic              w_load;
    logic              w_flush;
    logic [ADDR_W-1:0] w_pc;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_instr;
    logic [ADDR_W-1:0] r_out_pc;

    assign w_accept  = r_out_valid && out_ready;
    assign w_advance = !r_out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fetch     = 1'b0;
        w_load      = 1'b0;
        w_flush     = 1'b0;
        case (r_state)
            IDLE: begin
                w_load = redirect_valid;
                if (start && !halt_req) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (redirect_valid) begin
                    w_load  = 1'b1;
                    w_flush = 1'b1;
                end else if (halt_req) begin
                    w_state_nxt = DRAIN;
                end else if (w_advance) begin
                    w_fetch = 1'b1;
                end
            end
            DRAIN: begin
                if (redirect_valid) begin
                    w_load      = 1'b1;
                    w_flush     = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_advance) begin
                    w_flush     = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load       (w_load),
        .i_load_addr  (redirect_addr),
        .i_inc        (w_fetch),
        .o_pc         (w_pc),
        .o_wrap_pulse (wrap_pulse)
    );

    // An accepted word without a refill (e.g. on the halt edge) must also empty the stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_instr <= '0;
            r_out_pc    <= '0;
        end else if (w_fetch) begin
            r_out_valid <= 1'b1;
            r_out_instr <= mem_data;
            r_out_pc    <= w_pc;
        end else if (w_flush || w_accept) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef INSTR_FETCH_COUNT_EN
    logic [31:0] r_fetch_count;

    // A redirect discards the in-flight word, so that handshake is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_count <= '0;
        end else if (w_accept && !redirect_valid) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign fetch_count = r_fetch_count;
`else
    assign fetch_count = '0;
`endif

    assign mem_addr  = w_pc;
    assign out_valid = r_out_valid;
    assign out_instr = r_out_instr;
    assign out_pc    = r_out_pc;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_instr_fetch_ctrl;

`ifdef INSTR_FETCH_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, halt_req, redirect_valid, out_ready;
    logic [5:0]  redirect_addr;
    logic [5:0]  mem_addr;
    logic [63:0] mem_data;
    logic        out_valid, busy, wrap_pulse;
    logic [63:0] out_instr;
    logic [5:0]  out_pc;
    logic [31:0] fetch_count;
    logic [63:0] mem [64];

    int n_chk  = 0;
    int n_fail = 0;

    instr_fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .halt_req       (halt_req),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .busy           (busy),
        .wrap_pulse     (wrap_pulse),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;
    assign mem_data = mem[mem_addr];

    initial begin
        #500000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0;
        redirect_addr = '0; out_ready = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0;
        redirect_addr = '0; out_ready = 1'b0;
        #3;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
        n_chk++; if (out_instr !== 64'd0) begin n_fail++; $display("FAIL reset_instr got=%0h exp=0", out_instr); end
        n_chk++; if (out_pc !== 6'd0) begin n_fail++; $display("FAIL reset_out_pc got=%0d exp=0", out_pc); end
        n_chk++; if (mem_addr !== 6'd0) begin n_fail++; $display("FAIL reset_pc got=%0d exp=0", mem_addr); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        n_chk++; if (wrap_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_wrap got=%0b exp=0", wrap_pulse); end
        n_chk++; if (fetch_count !== 32'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", fetch_count); end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Start pulse then stream words 0..5 with out_ready held high.
    task automatic test_stream();
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL start_busy got=%0b exp=1", busy); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL start_no_fetch got=%0b exp=0", out_valid); end
        for (int k = 0; k < 6; k++) begin
            tick();
            n_chk++; if (out_instr !== 64'(k) || out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_instr got=%0d/v%0b exp=%0d/v1", out_instr, out_valid, k); end
            n_chk++; if (out_pc !== 6'(k)) begin n_fail++; $display("FAIL stream_out_pc got=%0d exp=%0d", out_pc, k); end
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_chk++; if (out_instr !== 64'd5 || out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_instr got=%0d/v%0b exp=5/v1", out_instr, out_valid); end
            n_chk++; if (mem_addr !== 6'd6) begin n_fail++; $display("FAIL stall_pc got=%0d exp=6", mem_addr); end
        end
        out_ready = 1'b1;
        tick();
        n_chk++; if (out_instr !== 64'd6) begin n_fail++; $display("FAIL stall_release got=%0d exp=6", out_instr); end
        tick();
        n_chk++; if (out_instr !== 64'd7) begin n_fail++; $display("FAIL stall_next got=%0d exp=7", out_instr); end
        n_chk++; if (fetch_count !== (CNT_EN ? 32'd7 : 32'd0)) begin n_fail++; $display("FAIL stall_count got=%0d exp=%0d", fetch_count, CNT_EN ? 7 : 0); end
    endtask

    task automatic test_redirect();
        repeat (3) tick();
        n_chk++; if (out_instr !== 64'd10) begin n_fail++; $display("FAIL redir_pre got=%0d exp=10", out_instr); end
        redirect_valid = 1'b1;
        redirect_addr  = 6'd40;
        tick();
        redirect_valid = 1'b0;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush got=%0b exp=0", out_valid); end
        n_chk++; if (mem_addr !== 6'd40) begin n_fail++; $display("FAIL redir_pc got=%0d exp=40", mem_addr); end
        n_chk++; if (fetch_count !== (CNT_EN ? 32'd10 : 32'd0)) begin n_fail++; $display("FAIL redir_nocount got=%0d exp=%0d", fetch_count, CNT_EN ? 10 : 0); end
        tick();
        n_chk++; if (out_instr !== 64'd40 || out_pc !== 6'd40 || out_valid !== 1'b1) begin n_fail++; $display("FAIL redir_first got=%0d@%0d exp=40@40", out_instr, out_pc); end
        tick();
        n_chk++; if (out_instr !== 64'd41) begin n_fail++; $display("FAIL redir_second got=%0d exp=41", out_instr); end
        n_chk++; if (fetch_count !== (CNT_EN ? 32'd11 : 32'd0)) begin n_fail++; $display("FAIL redir_count got=%0d exp=%0d", fetch_count, CNT_EN ? 11 : 0); end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1;
        redirect_addr  = 6'd62;
        tick();
        redirect_valid = 1'b0;
        tick();
        n_chk++; if (out_instr !== 64'd62 || wrap_pulse !== 1'b0) begin n_fail++; $display("FAIL wrap_62 got=%0d w%0b exp=62 w0", out_instr, wrap_pulse); end
        tick();
        n_chk++; if (out_pc !== 6'd63 || wrap_pulse !== 1'b1) begin n_fail++; $display("FAIL wrap_63 got=%0d w%0b exp=63 w1", out_pc, wrap_pulse); end
        n_chk++; if (mem_addr !== 6'd0) begin n_fail++; $display("FAIL wrap_pc got=%0d exp=0", mem_addr); end
        tick();
        n_chk++; if (out_instr !== 64'd0 || wrap_pulse !== 1'b0) begin n_fail++; $display("FAIL wrap_0 got=%0d w%0b exp=0 w0", out_instr, wrap_pulse); end
        redirect_valid = 1'b1;
        redirect_addr  = 6'd0;
        tick();
        redirect_valid = 1'b0;
        n_chk++; if (wrap_pulse !== 1'b0) begin n_fail++; $display("FAIL wrap_redirect0 got=%0b exp=0", wrap_pulse); end
        n_chk++; if (fetch_count !== (CNT_EN ? 32'd13 : 32'd0)) begin n_fail++; $display("FAIL wrap_count got=%0d exp=%0d", fetch_count, CNT_EN ? 13 : 0); end
    endtask

    task automatic test_halt();
        tick();
        out_ready = 1'b0;
        tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        n_chk++; if (busy !== 1'b1 || out_valid !== 1'b1 || out_instr !== 64'd0) begin n_fail++; $display("FAIL halt_drain got=b%0b v%0b i%0d exp=b1 v1 i0", busy, out_valid, out_instr); end
        n_chk++; if (mem_addr !== 6'd1) begin n_fail++; $display("FAIL halt_nofetch got=%0d exp=1", mem_addr); end
        tick();
        n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL halt_hold got=%0b exp=1", out_valid); end
        out_ready = 1'b1;
        tick();
        n_chk++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL halt_idle got=b%0b v%0b exp=b0 v0", busy, out_valid); end
        n_chk++; if (fetch_count !== (CNT_EN ? 32'd14 : 32'd0)) begin n_fail++; $display("FAIL halt_count got=%0d exp=%0d", fetch_count, CNT_EN ? 14 : 0); end
        start = 1'b1; halt_req = 1'b1;
        tick();
        start = 1'b0; halt_req = 1'b0;
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_halt_idle got=%0b exp=0", busy); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        n_chk++; if (out_valid !== 1'b0 || mem_addr !== 6'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL midreset got=v%0b pc%0d b%0b exp=v0 pc0 b0", out_valid, mem_addr, busy); end
        n_chk++; if (fetch_count !== 32'd0) begin n_fail++; $display("FAIL midreset_count got=%0d exp=0", fetch_count); end
        tick();
        rst_n = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        n_chk++; if (out_instr !== 64'd3) begin n_fail++; $display("FAIL postreset_instr got=%0d exp=3", out_instr); end
        n_chk++; if (fetch_count !== (CNT_EN ? 32'd3 : 32'd0)) begin n_fail++; $display("FAIL postreset_count got=%0d exp=%0d", fetch_count, CNT_EN ? 3 : 0); end
    endtask

    // Reference model works at the level of "slot contents" and a run/drain mode.
    task automatic test_random();
        int          m_pc, m_opc, m_cnt;
        bit          m_run, m_drain, m_valid, m_wrap, acc;
        logic [63:0] m_instr;
        do_reset();
        m_pc = 0; m_opc = 0; m_cnt = 0; m_instr = '0;
        m_run = 0; m_drain = 0; m_valid = 0; m_wrap = 0;
        for (int c = 0; c < 400; c++) begin
            start          = ($urandom_range(0, 7) == 0);
            halt_req       = ($urandom_range(0, 19) == 0);
            redirect_valid = ($urandom_range(0, 14) == 0);
            redirect_addr  = ($urandom_range(0, 2) == 0) ? 6'd62 : 6'($urandom);
            out_ready      = ($urandom_range(0, 3) != 0);

            acc    = m_valid && out_ready;
            m_wrap = 0;
            if (acc && !redirect_valid) m_cnt++;
            if (!m_run && !m_drain) begin
                if (redirect_valid) m_pc = redirect_addr;
                if (start && !halt_req) m_run = 1;
            end else if (m_run) begin
                if (redirect_valid) begin
                    m_pc = redirect_addr; m_valid = 0;
                end else if (halt_req) begin
                    m_run = 0; m_drain = 1;
                    if (acc) m_valid = 0;
                end else if (!m_valid || out_ready) begin
                    m_instr = mem[m_pc]; m_opc = m_pc; m_valid = 1;
                    m_wrap  = (m_pc == 63);
                    m_pc    = (m_pc + 1) % 64;
                end
            end else begin
                if (redirect_valid) m_pc = redirect_addr;
                if (redirect_valid || !m_valid || out_ready) begin
                    m_valid = 0; m_drain = 0;
                end
            end

            tick();
            n_chk++; if (out_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid c=%0d got=%0b exp=%0b", c, out_valid, m_valid); end
            n_chk++; if (out_instr !== m_instr) begin n_fail++; $display("FAIL rnd_instr c=%0d got=%0h exp=%0h", c, out_instr, m_instr); end
            n_chk++; if (out_pc !== 6'(m_opc)) begin n_fail++; $display("FAIL rnd_out_pc c=%0d got=%0d exp=%0d", c, out_pc, m_opc); end
            n_chk++; if (mem_addr !== 6'(m_pc)) begin n_fail++; $display("FAIL rnd_pc c=%0d got=%0d exp=%0d", c, mem_addr, m_pc); end
            n_chk++; if (busy !== (m_run || m_drain)) begin n_fail++; $display("FAIL rnd_busy c=%0d got=%0b exp=%0b", c, busy, m_run || m_drain); end
            n_chk++; if (wrap_pulse !== m_wrap) begin n_fail++; $display("FAIL rnd_wrap c=%0d got=%0b exp=%0b", c, wrap_pulse, m_wrap); end
            n_chk++; if (fetch_count !== (CNT_EN ? 32'(m_cnt) : 32'd0)) begin n_fail++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, fetch_count, CNT_EN ? m_cnt : 0); end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 64'(i);
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_wrap();
        test_halt();
        test_reset_mid();
        // Distinct upper bits catch data-path bugs the index-valued memory would hide.
        for (int i = 0; i < 64; i++) mem[i] = {32'($urandom), 32'(i)};
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
Fetch sequencer for the 64-word x 64-bit instruction memory (6-bit word address, combinational read).
- Holds the program counter and drives the memory read address.
- Registers each fetched word into a one-entry output stage with a valid/ready handshake to decode.
- Handles start, halt/drain, branch redirect with flush, and PC wrap-around.

Parameters:
- ADDR_W, 6, instruction-memory word-address width (depth = 2^ADDR_W = 64)
- DATA_W, 64, instruction word width
- RESET_PC, 0, PC value loaded at reset

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle pulse; begin fetching from current PC
- halt_req  input  1  stop fetching, drain output stage, return to IDLE
- redirect_valid  input  1  branch/jump: flush and load PC
- redirect_addr  input  ADDR_W  new PC when redirect_valid=1
- mem_addr  output  ADDR_W  read address to instruction memory; always equals pc
- mem_data  input  DATA_W  combinational read data from instruction memory
- out_valid  output  1  out_instr/out_pc hold a valid fetched instruction
- out_ready  input  1  decode accepts when out_valid && out_ready
- out_instr  output  DATA_W  registered instruction word
- out_pc  output  ADDR_W  address out_instr was fetched from
- busy  output  1  state != IDLE
- wrap_pulse  output  1  one-cycle pulse when PC advances 63 -> 0
- fetch_count  output  32  accepted-instruction count (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC; state=IDLE; out_valid=0; out_instr=0; out_pc=0; wrap_pulse=0; fetch_count=0. Outputs take reset values immediately, not at the next edge.
- States: IDLE, RUN, DRAIN. busy is combinational from state.
- advance = !out_valid || out_ready (output stage free, or being emptied this cycle).
- IDLE:
  - start=1 and halt_req=0 -> RUN. No fetch on the start edge; the first word is registered on the following edge.
  - start=1 and halt_req=1 together -> stay IDLE.
  - redirect_valid loads pc; out_valid is already 0.
- RUN, priority order:
  1. redirect_valid: pc <= redirect_addr; out_valid <= 0 (in-flight word discarded even if out_ready=1); state stays RUN.
  2. halt_req: state <= DRAIN; no new fetch on this edge; pc unchanged.
  3. advance: out_instr <= mem_data; out_pc <= pc; out_valid <= 1; pc <= pc+1 mod 2^ADDR_W.
  4. Otherwise stall: all outputs and pc held.
- Latency: word at address A appears on out_instr one edge after pc=A with advance=1. Sustained throughput is 1 word/cycle while out_ready=1.
- wrap_pulse=1 for exactly the cycle after a fetch that advanced pc from 2^ADDR_W-1 to 0. A redirect to 0 does not pulse.
- DRAIN:
  - Holds out_valid until accepted. Acceptance (or out_valid already 0) -> out_valid <= 0, state <= IDLE.
  - redirect_valid in DRAIN: pc <= redirect_addr; out_valid <= 0; state <= IDLE.
- start is ignored outside IDLE. halt_req in IDLE or DRAIN has no effect.
- mem_addr = pc combinationally. mem_data is sampled only on fetching edges.
- Reset asserted mid-operation discards the output stage and returns to IDLE with pc=RESET_PC.

Optional Feature:
- Macro: INSTR_FETCH_COUNT_EN.
- Defined: 32-bit counter increments on every out_valid && out_ready edge and wraps at 2^32. A redirect does not count the flushed word. The counter is cleared only by reset.
- Undefined: fetch_count is tied to 32'd0, no counter flops are generated, and the port list is unchanged.

Decomposition:
- Shared package fetch_pkg: state encoding constants (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2), ADDR_W/DATA_W defaults, RESET_PC default.
- One sub-module is natural: fetch_pc_reg. It holds pc with load (redirect), increment (fetch) and wrap detect, and drives wrap_pulse.
- The FSM and output stage stay in instr_fetch_ctrl.

Test Plan:
- Memory word i = i. Reset, start pulse, out_ready=1 -> out_instr 0,1,2,... on consecutive cycles; out_pc matches; busy=1.
- out_ready=0 for 3 cycles while out_valid with out_instr=5 -> out_instr stays 5, pc stays 6. On release, 6 follows 5 with no gap or duplicate.
- redirect_valid with redirect_addr=40 while out_instr=10 is valid and out_ready=1 -> word 10 is not counted. Next valid out_instr=40, then 41.
- Run from pc=62 -> out_instr 62, 63, 0. wrap_pulse is high one cycle, aligned with out_pc=63 being registered.
- halt_req with out_valid=1 and out_ready=0 -> state DRAIN, no new fetch. Set out_ready=1 -> one acceptance, then IDLE, busy=0, out_valid=0.
- rst_n low mid-RUN -> immediate out_valid=0, pc=0. With INSTR_FETCH_COUNT_EN, fetch_count=0 after reset and equals the number of handshakes afterwards.
